// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the serial pattern generator.
// Latency: n/a (types, constants and a combinational parity helper).
// Backpressure: n/a.
// Contents: FSM state enum, default widths, even-parity function.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam int SEQ_PAT_W = 8;
  localparam int SEQ_LEN_W = 4;
  localparam int SEQ_CNT_W = 4;
  localparam int SEQ_GAP_W = 4;

  // Widest pattern the parity helper accepts.
  localparam int SEQ_PAR_MAX_W = 32;

  // Even parity over the low n bits of d.
  function automatic logic even_parity(input logic [SEQ_PAR_MAX_W-1:0] d,
                                       input int unsigned n);
    logic p;
    p = 1'b0;
    for (int unsigned i = 0; i < SEQ_PAR_MAX_W; i++) begin
      if (i < n) p = p ^ d[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/seq_piso.sv
// Loadable parallel-in serial-out register, MSB-first over a variable length.
// Latency: bit_o reflects the loaded word's bit len-1 the cycle after load_i.
// Backpressure: shift_i low freezes the bit index (caller maps hold onto it).
// Ports: clk, rst (async active-low); load_i captures data_i/len_i,
//        restart_i rewinds to bit len-1, shift_i steps toward bit 0;
//        bit_o is the current bit, last_o is high while bit 0 is selected.
module seq_piso #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             restart_i,
  input  logic             shift_i,
  input  logic [PAT_W-1:0] data_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             bit_o,
  output logic             last_o
);

  logic [PAT_W-1:0] data_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else if (load_i) begin
      data_q <= data_i;
      len_q  <= len_i;
      idx_q  <= len_i - LEN_W'(1);
    end else if (restart_i) begin
      idx_q  <= len_q - LEN_W'(1);
    end else if (shift_i) begin
      idx_q  <= idx_q - LEN_W'(1);
    end
  end

  // Mask-select keeps every bit of the index meaningful.
  assign bit_o  = |(data_q & (PAT_W'(1) << idx_q));
  assign last_o = (idx_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: repeats a captured pattern MSB-first with idle gaps.
// Latency: first bit on line_o the cycle after an accepted start; done_o one cycle after last bit.
// Backpressure: hold_i freezes shifting and gap counting (line_oe_o low) while high.
// Ports: clk, rst (async active-low); start_i, pattern_i, len_i, reps_i, gap_i
//        captured on start in IDLE; hold_i pause; line_o/line_oe_o serial pair;
//        busy_o, done_o status. Optional parity beat: define SEQ_GEN_PARITY_EN.
import seq_gen_pkg::*;

module seq_pattern_gen #(
  parameter int PAT_W = SEQ_PAT_W,
  parameter int LEN_W = SEQ_LEN_W,
  parameter int CNT_W = SEQ_CNT_W,
  parameter int GAP_W = SEQ_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [CNT_W-1:0] reps_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic             hold_i,
  output logic             line_o,
  output logic             line_oe_o,
  output logic             busy_o,
  output logic             done_o
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] reps_left_q, reps_left_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             line_q, line_d;
  logic             piso_load, piso_restart, piso_shift;
  logic             piso_bit, piso_last;
  logic             cur_bit, beat_last, len_ok;

  seq_piso #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_piso (
    .clk       (clk),
    .rst       (rst),
    .load_i    (piso_load),
    .restart_i (piso_restart),
    .shift_i   (piso_shift),
    .data_i    (pattern_i),
    .len_i     (len_i),
    .bit_o     (piso_bit),
    .last_o    (piso_last)
  );

  assign len_ok = (len_i != '0) && (len_i <= LEN_W'(PAT_W));

`ifdef SEQ_GEN_PARITY_EN
  logic par_q, par_d, par_beat_q, par_beat_d;
  // The parity beat follows bit 0 and closes the repetition.
  assign cur_bit   = par_beat_q ? par_q : piso_bit;
  assign beat_last = par_beat_q;
`else
  assign cur_bit   = piso_bit;
  assign beat_last = piso_last;
`endif

  always_comb begin
    state_d      = state_q;
    reps_left_d  = reps_left_q;
    gap_d        = gap_q;
    gap_cnt_d    = gap_cnt_q;
    line_d       = line_q;
    piso_load    = 1'b0;
    piso_restart = 1'b0;
    piso_shift   = 1'b0;
    line_o       = 1'b0;
    line_oe_o    = 1'b0;
    busy_o       = (state_q != ST_IDLE);
    done_o       = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
    par_d        = par_q;
    par_beat_d   = par_beat_q;
`endif
    case (state_q)
      ST_IDLE: begin
        line_d = 1'b0;
        if (start_i && len_ok) begin
          piso_load   = 1'b1;
          reps_left_d = (reps_i == '0) ? '0 : reps_i - CNT_W'(1);
          gap_d       = gap_i;
          state_d     = ST_SHIFT;
`ifdef SEQ_GEN_PARITY_EN
          par_d      = even_parity(SEQ_PAR_MAX_W'(pattern_i), int unsigned'(len_i));
          par_beat_d = 1'b0;
`endif
        end
      end
      ST_SHIFT: begin
        // Mealy on hold: a paused beat shows the previous bit with oe low.
        line_o    = hold_i ? line_q : cur_bit;
        line_oe_o = ~hold_i;
        if (!hold_i) begin
          line_d = cur_bit;
          if (beat_last) begin
`ifdef SEQ_GEN_PARITY_EN
            par_beat_d = 1'b0;
`endif
            if (reps_left_q != '0) begin
              reps_left_d = reps_left_q - CNT_W'(1);
              if (gap_q != '0) begin
                state_d   = ST_GAP;
                gap_cnt_d = gap_q;
              end else begin
                piso_restart = 1'b1;
              end
            end else begin
              state_d = ST_DONE;
            end
          end
`ifdef SEQ_GEN_PARITY_EN
          else if (piso_last) begin
            par_beat_d = 1'b1;
          end
`endif
          else begin
            piso_shift = 1'b1;
          end
        end
      end
      ST_GAP: begin
        line_d = 1'b0;
        if (!hold_i) begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
          if (gap_cnt_q == GAP_W'(1)) begin
            state_d      = ST_SHIFT;
            piso_restart = 1'b1;
          end
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        line_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      reps_left_q <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      line_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      reps_left_q <= reps_left_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      line_q      <= line_d;
    end
  end

`ifdef SEQ_GEN_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q      <= 1'b0;
      par_beat_q <= 1'b0;
    end else begin
      par_q      <= par_d;
      par_beat_q <= par_beat_d;
    end
  end
`endif

endmodule
